// File: rtl/io_channel_unit.sv
// io_channel_unit: CPU input/output unit between the control unit and the board I/O.
// Input instructions stall the CPU until the confirm button is pressed and released, then
// return the switch bank on du. Output instructions latch dm into one of CH display channels.
// The button is synchronised and debounced internally.
// Optional feature: define IO_OUT_AWAIT_EN to make output instructions also wait for the
// user to confirm (press + release) before retiring.

module io_channel_unit #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned IN_W       = 14,
    parameter int unsigned CH         = 4,
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned SEL_W      = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                 clk,
    input  logic                 HardReset,
    input  logic                 inop,
    input  logic                 outop,
    input  logic [SEL_W-1:0]     ch_sel,
    input  logic [IN_W-1:0]      in,
    input  logic                 bt,
    input  logic [DATA_W-1:0]    dm,
    output logic [DATA_W-1:0]    du,
    output logic                 await,
    output logic [CH*DATA_W-1:0] out_data,
    output logic [CH-1:0]        out_valid
);

    localparam int unsigned    CNT_W  = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWaitPress,
        StWaitRelease,
        StDone
    } state_e;

    // ------------------------------------------------------------------
    // Button synchroniser and debouncer
    // ------------------------------------------------------------------
    logic             bt_meta_q;
    logic             bt_s_q;
    logic             bt_db_q, bt_db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bt_differ;
    logic             bt_flip;
    logic             press_pulse;
    logic             release_pulse;

    // Two-flop synchroniser for the asynchronous push-button.
    always_ff @(posedge clk or posedge HardReset) begin
        if (HardReset) begin
            bt_meta_q <= 1'b0;
            bt_s_q    <= 1'b0;
        end else begin
            bt_meta_q <= bt;
            bt_s_q    <= bt_meta_q;
        end
    end

    assign bt_differ = (bt_s_q != bt_db_q);
    // Flip on the DEB_CYCLES-th consecutive cycle of disagreement.
    assign bt_flip   = bt_differ && (cnt_q == CntMax);

    // Edge pulses fire in the cycle whose closing edge toggles bt_db.
    assign press_pulse   = bt_flip && !bt_db_q;
    assign release_pulse = bt_flip &&  bt_db_q;

    // Debounce counter next state: clear on agreement, count while disagreeing.
    always_comb begin
        bt_db_d = bt_db_q;
        cnt_d   = cnt_q;
        if (!bt_differ) begin
            cnt_d = '0;
        end else if (bt_flip) begin
            cnt_d   = '0;
            bt_db_d = ~bt_db_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Debounced level and counter registers.
    always_ff @(posedge clk or posedge HardReset) begin
        if (HardReset) begin
            bt_db_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            bt_db_q <= bt_db_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    state_e state_q, state_d;
    logic   ch_ok;
    logic   wr_en;
    logic   cap_en;

    // Out-of-range selects only exist when CH is not a power of two.
    assign ch_ok = (32'(ch_sel) < CH);

`ifdef IO_OUT_AWAIT_EN
    // Marks a wait sequence started by outop so du is left untouched.
    logic out_flag_q, out_flag_d;
`endif

    // Next-state logic; inop has priority over outop in IDLE.
    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        cap_en  = 1'b0;
`ifdef IO_OUT_AWAIT_EN
        out_flag_d = out_flag_q;
`endif
        case (state_q)
            StIdle: begin
                if (inop) begin
                    state_d = StWaitPress;
`ifdef IO_OUT_AWAIT_EN
                    out_flag_d = 1'b0;
`endif
                end else if (outop) begin
                    wr_en = ch_ok;
`ifdef IO_OUT_AWAIT_EN
                    state_d    = StWaitPress;
                    out_flag_d = 1'b1;
`endif
                end
            end
            StWaitPress: begin
                if (press_pulse) begin
`ifdef IO_OUT_AWAIT_EN
                    cap_en = !out_flag_q;
`else
                    cap_en = 1'b1;
`endif
                    state_d = StWaitRelease;
                end
            end
            StWaitRelease: begin
                if (release_pulse) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge HardReset) begin
        if (HardReset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef IO_OUT_AWAIT_EN
    // Output-path flag register.
    always_ff @(posedge clk or posedge HardReset) begin
        if (HardReset) begin
            out_flag_q <= 1'b0;
        end else begin
            out_flag_q <= out_flag_d;
        end
    end
`endif

    // Stall request; low in DONE so the CPU retires on that edge.
    always_comb begin
        await = ((state_q == StIdle) && inop) ||
                (state_q == StWaitPress)      ||
                (state_q == StWaitRelease);
`ifdef IO_OUT_AWAIT_EN
        await = await || ((state_q == StIdle) && outop);
`endif
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]           du_q;
    logic [CH-1:0][DATA_W-1:0]   out_data_q;
    logic [CH-1:0]               out_valid_q;

    // Captured user data; holds until the next capture.
    always_ff @(posedge clk or posedge HardReset) begin
        if (HardReset) begin
            du_q <= '0;
        end else if (cap_en) begin
            du_q <= DATA_W'(in);
        end
    end

    // Channel registers and their written-since-reset flags.
    always_ff @(posedge clk or posedge HardReset) begin
        if (HardReset) begin
            out_data_q  <= '0;
            out_valid_q <= '0;
        end else if (wr_en) begin
            out_data_q[ch_sel]  <= dm;
            out_valid_q[ch_sel] <= 1'b1;
        end
    end

    assign du        = du_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_io_channel_unit.sv
// Self-checking bench for io_channel_unit: directed scenarios plus randomized stimulus,
// checked every cycle against a behavioural model of the button/handshake rules.

module tb_io_channel_unit;

    localparam int DATA_W = 32;
    localparam int IN_W   = 14;
    localparam int CH     = 4;
    localparam int DEB    = 4;
    localparam int SEL_W  = 2;

    logic                 clk = 1'b0;
    logic                 HardReset;
    logic                 inop;
    logic                 outop;
    logic [SEL_W-1:0]     ch_sel;
    logic [IN_W-1:0]      in_sw;
    logic                 bt;
    logic [DATA_W-1:0]    dm;
    logic [DATA_W-1:0]    du;
    logic                 await;
    logic [CH*DATA_W-1:0] out_data;
    logic [CH-1:0]        out_valid;

    int checks = 0;
    int errors = 0;

    io_channel_unit #(
        .DATA_W    (DATA_W),
        .IN_W      (IN_W),
        .CH        (CH),
        .DEB_CYCLES(DEB),
        .SEL_W     (SEL_W)
    ) dut (
        .clk      (clk),
        .HardReset(HardReset),
        .inop     (inop),
        .outop    (outop),
        .ch_sel   (ch_sel),
        .in       (in_sw),
        .bt       (bt),
        .dm       (dm),
        .du       (du),
        .await    (await),
        .out_data (out_data),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    bit              m_s1 = 0, m_s2 = 0;   // raw button seen 1 and 2 edges ago
    bit              m_db = 0;             // debounced level
    int              m_run = 0;            // consecutive samples disagreeing with m_db
    int              m_phase = 0;          // 0 idle, 1 wait press, 2 wait release, 3 done
    bit              m_out_seq = 0;        // current wait was started by outop
    logic [31:0]     m_du = '0;
    logic [31:0]     m_ch [CH];
    logic [CH-1:0]   m_valid = '0;

    function automatic bit exp_await();
        bit a;
        a = (m_phase == 0 && inop) || m_phase == 1 || m_phase == 2;
`ifdef IO_OUT_AWAIT_EN
        a = a || (m_phase == 0 && outop);
`endif
        return a;
    endfunction

    task automatic m_reset();
        m_s1 = 0; m_s2 = 0; m_db = 0; m_run = 0;
        m_phase = 0; m_out_seq = 0; m_du = '0; m_valid = '0;
        for (int i = 0; i < CH; i++) m_ch[i] = '0;
    endtask

    task automatic m_step();
        bit press, rel, flip;
        flip = 0;
        if (m_s2 != m_db) begin
            m_run++;
            if (m_run == DEB) flip = 1;
        end else begin
            m_run = 0;
        end
        press = flip && !m_db;
        rel   = flip &&  m_db;
        if (flip) begin
            m_db  = !m_db;
            m_run = 0;
        end
        m_s2 = m_s1;
        m_s1 = bt;
        case (m_phase)
            0: begin
                if (inop) begin
                    m_phase = 1; m_out_seq = 0;
                end else if (outop) begin
                    if (int'(ch_sel) < CH) begin
                        m_ch[ch_sel]    = dm;
                        m_valid[ch_sel] = 1'b1;
                    end
`ifdef IO_OUT_AWAIT_EN
                    m_phase = 1; m_out_seq = 1;
`endif
                end
            end
            1: if (press) begin
                if (!m_out_seq) m_du = 32'(in_sw);
                m_phase = 2;
            end
            2: if (rel) m_phase = 3;
            default: m_phase = 0;
        endcase
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge HardReset);
            if (HardReset) m_reset();
            else m_step();
        end
    end

    // Compare every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("await", {63'd0, await}, {63'd0, exp_await()});
            chk("du", {32'd0, du}, {32'd0, m_du});
            chk("out_valid", {60'd0, out_valid}, {60'd0, m_valid});
            for (int i = 0; i < CH; i++)
                chk("out_data", {32'd0, out_data[i*DATA_W +: DATA_W]}, {32'd0, m_ch[i]});
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Press for hold cycles, release, wait for DONE, then retire the instruction.
    task automatic press_release(input int hold);
        bit seen;
        seen = 0;
        bt = 1'b1;
        repeat (hold) tick();
        bt = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!await) begin
                seen = 1;
                break;
            end
        end
        chk("done_reached", {63'd0, seen}, 64'd1);
        inop  = 1'b0;
        outop = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        int n;
        int bt_left;
        HardReset = 1'b1;
        inop = 0; outop = 0; ch_sel = '0; in_sw = '0; bt = 0; dm = '0;
        repeat (3) tick();
        chk("rst_du", {32'd0, du}, 64'd0);
        chk("rst_await", {63'd0, await}, 64'd0);
        chk("rst_out_data", out_data[63:0], 64'd0);
        chk("rst_out_valid", {60'd0, out_valid}, 64'd0);
        HardReset = 1'b0;
        tick();

        // Output write to channel 2.
        outop = 1; ch_sel = 2'd2; dm = 32'h0000_00A5;
        @(negedge clk);
`ifdef IO_OUT_AWAIT_EN
        chk("out_await", {63'd0, await}, 64'd1);
`else
        chk("out_no_stall", {63'd0, await}, 64'd0);
`endif
        tick();
        outop = 0;
        @(negedge clk);
        chk("ch2_data", {32'd0, out_data[2*DATA_W +: DATA_W]}, 64'h0000_00A5);
        chk("ch2_valid", {60'd0, out_valid}, 64'b0100);
`ifdef IO_OUT_AWAIT_EN
        press_release(6);
`else
        chk("out_no_stall2", {63'd0, await}, 64'd0);
        tick();
`endif

        // Input capture: 10-cycle press, DONE six edges after the release.
        inop = 1; in_sw = 14'h1ABC;
        #1;
        chk("await_cycle0", {63'd0, await}, 64'd1);
        bt = 1;
        repeat (10) tick();
        bt = 0;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (!await) break;
        end
        chk("done_latency", 64'(n), 64'd6);
        chk("du_capture", {32'd0, du}, 64'h0000_1ABC);
        @(posedge clk);
        @(negedge clk);
        chk("done_one_cycle", {63'd0, await}, 64'd1);
        inop = 0;
        tick();

        // Bounce rejection: five 3-cycle pulses during WAIT_PRESS.
        inop = 1; in_sw = 14'h0155;
        repeat (5) begin
            bt = 1;
            repeat (3) tick();
            bt = 0;
            repeat (3) tick();
        end
        repeat (4) tick();
        @(negedge clk);
        chk("bounce_await", {63'd0, await}, 64'd1);
        chk("bounce_du", {32'd0, du}, 64'h0000_1ABC);
        tick();
        press_release(7);
        chk("du_after_bounce", {32'd0, du}, 64'h0000_0155);

        // Priority: inop wins over outop.
        inop = 1; outop = 1; ch_sel = 2'd1; dm = 32'hDEAD_BEEF;
        tick();
        inop = 0; outop = 0;
        @(negedge clk);
        chk("prio_ch1", {32'd0, out_data[1*DATA_W +: DATA_W]}, 64'd0);
        chk("prio_valid", {60'd0, out_valid}, 64'b0100);
        chk("prio_wait", {63'd0, await}, 64'd1);
        tick();
        press_release(6);

`ifdef IO_OUT_AWAIT_EN
        // Output with stall: channel 3 written at once, du untouched.
        outop = 1; ch_sel = 2'd3; dm = 32'd7; in_sw = 14'h2222;
        tick();
        outop = 0;
        @(negedge clk);
        chk("ch3_data", {32'd0, out_data[3*DATA_W +: DATA_W]}, 64'd7);
        chk("ch3_await", {63'd0, await}, 64'd1);
        tick();
        press_release(6);
        chk("ch3_du", {32'd0, du}, 64'h0000_0155);
`endif

        // Reset in the middle of WAIT_RELEASE.
        inop = 1; in_sw = 14'h3FFF; bt = 1;
        repeat (10) tick();
        @(negedge clk);
        chk("pre_reset_await", {63'd0, await}, 64'd1);
        #2;
        inop = 0; HardReset = 1;
        #1;
        chk("mid_rst_await", {63'd0, await}, 64'd0);
        chk("mid_rst_du", {32'd0, du}, 64'd0);
        chk("mid_rst_data", {32'd0, out_data[2*DATA_W +: DATA_W]}, 64'd0);
        chk("mid_rst_valid", {60'd0, out_valid}, 64'd0);
        bt = 0;
        tick();
        HardReset = 0;
        tick();

        // Randomized traffic with occasional asynchronous resets.
        bt_left = 1;
        for (int c = 0; c < 3000; c++) begin
            tick();
            inop   = ($urandom_range(0, 7) == 0);
            outop  = ($urandom_range(0, 3) == 0);
            ch_sel = SEL_W'($urandom);
            dm     = $urandom;
            in_sw  = IN_W'($urandom);
            bt_left--;
            if (bt_left <= 0) begin
                bt = ~bt;
                bt_left = $urandom_range(1, 9);
            end
            if ($urandom_range(0, 599) == 0) begin
                #2 HardReset = 1;
                #2 HardReset = 0;
            end
        end
        inop = 0; outop = 0; bt = 0;
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_channel_unit.md
# io_channel_unit

Parametrised CPU input/output unit that sits between the control unit (`inop`/`outop`) and the board switches, push-button and displays. Input instructions stall the CPU through `await` until the user presses and releases the confirm button, then return the switch value on `du`. Output instructions latch `dm` into one of `CH` independent display channels. Optionally, output instructions also stall until the user confirms. Unlike the previous IO unit, button debouncing and synchronisation are internal, and the clock is free-running rather than a divided CPU clock.

## Interface
- `DATA_W`, 32: CPU data width (`dm`, `du`, channel width).
- `IN_W`, 14: switch input width; must satisfy IN_W ≤ DATA_W.
- `CH`, 4: number of output channels, ≥1.
- `DEB_CYCLES`, 16: debounce stability count, ≥2.
- `SEL_W`, `$clog2(CH)` (min 1): channel select width.

Ports:
- `clk`  in  1: system clock, rising edge.
- `HardReset`  in  1: reset; asynchronous, active-high.
- `inop`  in  1: input instruction in execute, from UC.
- `outop`  in  1: output instruction in execute, from UC.
- `ch_sel`  in  SEL_W: target channel for `outop`.
- `in`  in  IN_W: raw switch bank.
- `bt`  in  1: raw confirm button, 1 = pressed (top level inverts the board key).
- `dm`  in  DATA_W: data to display.
- `du`  out  DATA_W: captured user data, zero-extended from `in`.
- `await`  out  1: CPU stall request.
- `out_data`  out  CH*DATA_W: channel registers; channel i at [i*DATA_W +: DATA_W].
- `out_valid`  out  CH: channel i written since reset.

## Operation
- **Button path:**
  - 2-flop synchroniser on `bt`, producing `bt_s`.
  - Debouncer holds level `bt_db` and a counter. The counter clears when `bt_s == bt_db` and increments while they differ.
  - When the counter is at DEB_CYCLES-1 and they still differ, `bt_db` toggles and the counter clears.
  - `press` = one-cycle pulse on a `bt_db` 0→1 transition. `release` = one-cycle pulse on a 1→0 transition.
- **FSM states:** IDLE, WAIT_PRESS, WAIT_RELEASE, DONE.
  - **IDLE:**
    - `inop` → WAIT_PRESS.
    - `outop` → write `dm` to `ch_sel` this edge, set `out_valid[ch_sel]`; stay IDLE (see Configuration).
  - **WAIT_PRESS:** on `press`, latch `du` = {0, `in`} → WAIT_RELEASE.
  - **WAIT_RELEASE:** on `release` → DONE.
  - **DONE:** unconditional → IDLE after one cycle.
- **`await` (combinational):** (IDLE & `inop`) | WAIT_PRESS | WAIT_RELEASE. It is 0 in DONE, so the CPU retires the IO instruction on the DONE edge.
- **Priority and edge cases:**
  - `inop` and `outop` together in IDLE: `inop` wins and `outop` is ignored.
  - `ch_sel` ≥ CH (non-power-of-2 CH): write dropped and `out_valid` unchanged.
  - `inop`/`outop` are ignored outside IDLE.
  - A button already held when `inop` arrives produces no `press` until it is released and pressed again.
  - `du` holds its value until the next capture.

## Timing
- **Reset values:** `du`=0, `await`=0 (FSM IDLE, inputs low), `out_data`=0, `out_valid`=0, `bt_db`=0, counter=0, synchroniser=0.
- **Reset mid-operation:** the FSM returns to IDLE asynchronously and any pending capture is lost.
- **Button latency:** for a `bt` rising edge held stable, `bt_db` rises on the (DEB_CYCLES+2)th rising `clk` edge after it. A glitch shorter than DEB_CYCLES cycles at `bt_s` produces no transition.
- **`outop` (no stall):** register updates on the same edge it is sampled; `out_data` is visible next cycle.
- **`inop`:** `await` goes high combinationally in the same cycle. `du` is valid from the cycle after `press` and is stable in DONE.
- **Counter width:** `$clog2(DEB_CYCLES)`; never wraps, because it clears at DEB_CYCLES-1.

## Configuration
- **`IO_OUT_AWAIT_EN` defined:**
  - `outop` in IDLE writes the channel on that edge, then enters WAIT_PRESS, which is shared with `inop` but flagged as output.
  - `await` also includes (IDLE & `outop`).
  - `du` is not updated on the output path; the rest of the sequence, through DONE, is identical.
- **Undefined:** `outop` completes in one cycle with no stall, and the WAIT states are reachable only via `inop`.

## Test plan
Bench uses DEB_CYCLES=4, CH=4.
- **Reset:** assert `HardReset` mid-WAIT_RELEASE → `await`=0, `du`=0, `out_data`=0, `out_valid`=0 immediately.
- **Output write:** `outop`=1, `ch_sel`=2, `dm`=0x0000_00A5 for 1 cycle → channel 2 = 0xA5, `out_valid`=4'b0100, `await` never high (macro undefined).
- **Input capture:** `inop`=1, `in`=14'h1ABC; hold `bt` 10 cycles, then release → `await` high from cycle 0; `du`=0x0000_1ABC; `await` low exactly one cycle (DONE), 6 cycles after the release edge.
- **Bounce rejection:** during WAIT_PRESS, pulse `bt` high for 3 cycles, 5 times → no `press`, `await` stays 1, `du` unchanged.
- **Priority:** `inop`=`outop`=1, `ch_sel`=1 → channel 1 unchanged, FSM enters WAIT_PRESS.
- **`IO_OUT_AWAIT_EN` defined:** `outop`, `ch_sel`=3, `dm`=7 → channel 3 = 7 next cycle; `await` held until press+release; `du` unchanged.
